// File: rtl/id_pkg.sv
// Shared decode constants and ID/EX boundary types for the ID stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_LOGIC = 2'b10,
    ALU_SLT   = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(10'b0);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jtarg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } idex_t;

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational read ports with same-cycle WB bypass,
// one write port, $0 hardwired to zero.
module reg_file_32x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b
);

  logic [31:0][31:0] regs_q, regs_d;
  logic              wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // Bypass lets an instruction read the value WB is writing this same edge.
  always_comb begin
    rd_a = regs_q[ra_a];
    rd_b = regs_q[ra_b];
    if (wr_en && wa == ra_a) rd_a = wd;
    if (wr_en && wa == ra_b) rd_b = wd;
    if (ra_a == 5'd0) rd_a = '0;
    if (ra_b == 5'd0) rd_b = '0;
  end

endmodule

// File: rtl/stage_id.sv
// MIPS instruction-decode stage: register read, control decode, load-use
// hazard detection and the ID/EX pipeline register.
module stage_id
  import id_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'd4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IFout_PC4,
  input  logic [31:0] IFout_Inst,
  input  logic        MEM_PCSrc,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_Rd,
  input  logic [31:0] WB_Data,
  output logic        stall,
  output logic [31:0] IDout_PC4,
  output logic [31:0] IDout_RsData,
  output logic [31:0] IDout_RtData,
  output logic [31:0] IDout_Imm,
  output logic [31:0] IDout_Jtarg,
  output logic [4:0]  IDout_Rs,
  output logic [4:0]  IDout_Rt,
  output logic [4:0]  IDout_Rd,
  output logic [9:0]  IDout_Ctrl
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data;
  logic        uses_rt, stall_c, bubble;
  ctrl_t       ctrl_dec;
  idex_t       idex_d, idex_q, idex_rst;

  assign opcode = IFout_Inst[31:26];
  assign rs     = IFout_Inst[25:21];
  assign rt     = IFout_Inst[20:16];
  assign rd     = IFout_Inst[15:11];
  assign funct  = IFout_Inst[5:0];

  reg_file_32x32 u_rf (
    .clk  (Clk),
    .rst  (Clr),
    .ra_a (rs),
    .ra_b (rt),
    .we   (WB_RegWrite),
    .wa   (WB_Rd),
    .wd   (WB_Data),
    .rd_a (rs_data),
    .rd_b (rt_data)
  );

  always_comb begin
    ctrl_dec = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:        ctrl_dec.alu_ctrl = ALU_ADD;
          FN_SUB:        ctrl_dec.alu_ctrl = ALU_SUB;
          FN_AND, FN_OR: ctrl_dec.alu_ctrl = ALU_LOGIC;
          FN_SLT:        ctrl_dec.alu_ctrl = ALU_SLT;
          default:       ctrl_dec = CTRL_BUBBLE;
        endcase
      end
      OP_LW: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.branch   = 1'b1;
        ctrl_dec.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
      end
      OP_J:    ctrl_dec.jump = 1'b1;
      default: ctrl_dec = CTRL_BUBBLE;
    endcase
  end

  // Only R-type, sw and beq actually consume rt as a source operand.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign stall_c = EX_MemRead && (EX_Rt != 5'd0) &&
                   ((EX_Rt == rs) || ((EX_Rt == rt) && uses_rt)) && !MEM_PCSrc;
  assign bubble  = stall_c || MEM_PCSrc;
  assign stall   = stall_c;

  always_comb begin
    idex_rst     = '0;
    idex_rst.pc4 = RESET_PC4;
  end

  always_comb begin
    idex_d.pc4     = bubble ? RESET_PC4 : IFout_PC4;
    idex_d.rs_data = rs_data;
    idex_d.rt_data = rt_data;
    idex_d.imm     = {{16{IFout_Inst[15]}}, IFout_Inst[15:0]};
    idex_d.jtarg   = {IFout_PC4[31:28], IFout_Inst[25:0], 2'b00};
    idex_d.rs      = rs;
    idex_d.rt      = rt;
    idex_d.rd      = rd;
    idex_d.ctrl    = bubble ? CTRL_BUBBLE : ctrl_dec;
  end

  always_ff @(posedge Clk) begin
    if (Clr) idex_q <= idex_rst;
    else     idex_q <= idex_d;
  end

  assign IDout_PC4    = idex_q.pc4;
  assign IDout_RsData = idex_q.rs_data;
  assign IDout_RtData = idex_q.rt_data;
  assign IDout_Imm    = idex_q.imm;
  assign IDout_Jtarg  = idex_q.jtarg;
  assign IDout_Rs     = idex_q.rs;
  assign IDout_Rt     = idex_q.rt;
  assign IDout_Rd     = idex_q.rd;
  assign IDout_Ctrl   = idex_q.ctrl;

endmodule

// File: tb/tb_stage_id.sv
// Bench for stage_id: directed scenarios then randomized traffic, all checked
// against a behavioural register-file/decode model.
module tb_stage_id;

  logic        Clk, Clr;
  logic [31:0] IFout_PC4, IFout_Inst, WB_Data;
  logic        MEM_PCSrc, EX_MemRead, WB_RegWrite;
  logic [4:0]  EX_Rt, WB_Rd;
  logic        stall;
  logic [31:0] IDout_PC4, IDout_RsData, IDout_RtData, IDout_Imm, IDout_Jtarg;
  logic [4:0]  IDout_Rs, IDout_Rt, IDout_Rd;
  logic [9:0]  IDout_Ctrl;

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0] mref [32];
  logic [31:0] e_pc4, e_rsd, e_rtd, e_imm, e_jt;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [9:0]  e_ctrl;

  stage_id #(.RESET_PC4(32'd4)) dut (
    .Clk(Clk), .Clr(Clr), .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst),
    .MEM_PCSrc(MEM_PCSrc), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .stall(stall), .IDout_PC4(IDout_PC4), .IDout_RsData(IDout_RsData),
    .IDout_RtData(IDout_RtData), .IDout_Imm(IDout_Imm), .IDout_Jtarg(IDout_Jtarg),
    .IDout_Rs(IDout_Rs), .IDout_Rt(IDout_Rt), .IDout_Rd(IDout_Rd),
    .IDout_Ctrl(IDout_Ctrl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Control bundle {RW,MtR,MR,MW,Br,J,ALUSrc,RegDst,ALU[1:0]} per instruction.
  function automatic logic [9:0] ref_ctrl(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    case (op)
      6'h00: case (fn)
        6'h20:        return 10'b1000000100;
        6'h22:        return 10'b1000000101;
        6'h24, 6'h25: return 10'b1000000110;
        6'h2A:        return 10'b1000000111;
        default:      return 10'b0;
      endcase
      6'h23:   return 10'b1110001000;
      6'h2B:   return 10'b0001001000;
      6'h04:   return 10'b0000100001;
      6'h08:   return 10'b1000001000;
      6'h02:   return 10'b0000010000;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wrd == idx) return wd;
    return mref[idx];
  endfunction

  task automatic cyc(input logic clr, input logic [31:0] pc4, input logic [31:0] inst,
                     input logic pcsrc, input logic mrd, input logic [4:0] ert,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    logic [4:0] rs, rt;
    logic       es;
    Clr = clr; IFout_PC4 = pc4; IFout_Inst = inst; MEM_PCSrc = pcsrc;
    EX_MemRead = mrd; EX_Rt = ert; WB_RegWrite = we; WB_Rd = wrd; WB_Data = wd;
    @(negedge Clk);
    rs = inst[25:21];
    rt = inst[20:16];
    es = mrd && ert != 0 && !pcsrc &&
         (ert == rs || (ert == rt && inst[31:26] inside {6'h00, 6'h2B, 6'h04}));
    chk("stall", {31'b0, stall}, {31'b0, es});
    if (clr) begin
      e_pc4 = 32'd4; e_rsd = 0; e_rtd = 0; e_imm = 0; e_jt = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_ctrl = 0;
    end else begin
      e_pc4  = (es || pcsrc) ? 32'd4 : pc4;
      e_ctrl = (es || pcsrc) ? 10'd0 : ref_ctrl(inst);
      e_rsd  = ref_read(rs, we, wrd, wd);
      e_rtd  = ref_read(rt, we, wrd, wd);
      e_imm  = 32'($signed(inst[15:0]));
      e_jt   = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
      e_rs = rs; e_rt = rt; e_rd = inst[15:11];
    end
    @(posedge Clk);
    if (clr) begin
      for (int i = 0; i < 32; i++) mref[i] = 32'd0;
    end else if (we && wrd != 0) begin
      mref[wrd] = wd;
    end
    #1;
    chk("pc4", IDout_PC4, e_pc4);
    chk("rs_data", IDout_RsData, e_rsd);
    chk("rt_data", IDout_RtData, e_rtd);
    chk("imm", IDout_Imm, e_imm);
    chk("jtarg", IDout_Jtarg, e_jt);
    chk("rs", {27'b0, IDout_Rs}, {27'b0, e_rs});
    chk("rt", {27'b0, IDout_Rt}, {27'b0, e_rt});
    chk("rd", {27'b0, IDout_Rd}, {27'b0, e_rd});
    chk("ctrl", {22'b0, IDout_Ctrl}, {22'b0, e_ctrl});
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0]  a, b, c;
    logic [5:0]  fn;
    logic [15:0] imm;
    a   = 5'($urandom_range(0, 7));
    b   = 5'($urandom_range(0, 7));
    c   = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      default: fn = 6'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, a, b, c, 5'd0, fn};
      3:       return {6'h23, a, b, imm};
      4:       return {6'h2B, a, b, imm};
      5:       return {6'h04, a, b, imm};
      6:       return {6'h08, a, b, imm};
      7:       return {6'h02, 26'($urandom)};
      8:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mref[i] = 32'd0;

    // Reset held two cycles; $5 then reads back as zero.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h55, 32'hFFFF_FFFF, 1, 1, 3, 1, 5, 32'hAAAA);
    chk("rst_pc4", IDout_PC4, 32'd4);
    chk("rst_ctrl", {22'b0, IDout_Ctrl}, 32'd0);
    cyc(0, 32'h100, 32'h00A0_4820, 0, 0, 0, 1, 3, 32'h1234_5678);
    chk("r5_zero", IDout_RsData, 32'd0);

    cyc(0, 32'h104, 32'h0063_2020, 0, 0, 0, 0, 0, 0);
    chk("add_rs", IDout_RsData, 32'h1234_5678);
    chk("add_ctrl", {22'b0, IDout_Ctrl}, 32'h204);

    cyc(0, 32'h108, 32'hAC07_FFFC, 0, 0, 0, 1, 7, 32'hDEAD_BEEF);
    chk("byp_rt", IDout_RtData, 32'hDEAD_BEEF);
    chk("sw_imm", IDout_Imm, 32'hFFFF_FFFC);

    cyc(0, 32'h10C, 32'h0041_2820, 0, 1, 2, 0, 0, 0);
    chk("lu_ctrl", {22'b0, IDout_Ctrl}, 32'd0);
    cyc(0, 32'h10C, 32'h0041_2820, 0, 0, 2, 0, 0, 0);
    chk("lu_rs", {27'b0, IDout_Rs}, 32'd2);

    cyc(0, 32'h110, 32'h0041_2820, 1, 1, 2, 0, 0, 0);
    chk("flush_ctrl", {22'b0, IDout_Ctrl}, 32'd0);

    cyc(0, 32'h8000_0010, 32'h0800_0040, 0, 0, 0, 0, 0, 0);
    chk("j_targ", IDout_Jtarg, 32'h8000_0100);
    cyc(0, 32'h114, 32'hFC00_0000, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h118, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
    chk("nop_ctrl", {22'b0, IDout_Ctrl}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom, rnd_inst(),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
